// File: rtl/reg_cmd_pkg.sv
// rtl/reg_cmd_pkg.sv - shared state type and protocol constants for reg_cmd_decoder
//
// Purpose: command opcodes, response bytes, read timeout and the decoder
// state enumeration, imported by reg_cmd_decoder.

package reg_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WSTROBE,
    ST_RSTROBE,
    ST_RWAIT,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_TX_ERR
  } state_t;

  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] RSP_ACK    = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h3F;
  localparam int         RD_TIMEOUT = 4;

endpackage

// File: rtl/reg_cmd_decoder.sv
// rtl/reg_cmd_decoder.sv - byte-stream write/read command decoder driving a register block
//
// Purpose: parses 'W' addr data[NB] and 'R' addr commands from an 8-bit rx
// stream, issues single-cycle write/read strobes and returns an ack, the read
// word (MSB byte first) or an error byte on an 8-bit tx stream.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_rx_data/valid, o_rx_ready   command byte stream in
//   o_tx_data/valid, i_tx_ready   response byte stream out
//   o_w_en/addr/value         register write port
//   o_r_en/addr, i_r_value/valid  register read port
//   o_err                     one-cycle pulse when an error byte is queued

module reg_cmd_decoder
  import reg_cmd_pkg::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  DEPTH    = 32,
  parameter int  DEPTH_RO = 32,
  localparam int NB       = WIDTH / 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int RAW      = $clog2(DEPTH + DEPTH_RO)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_w_en,
  output logic [AW-1:0]    o_w_addr,
  output logic [WIDTH-1:0] o_w_value,
  output logic             o_r_en,
  output logic [RAW-1:0]   o_r_addr,
  input  logic [WIDTH-1:0] i_r_value,
  input  logic             i_r_valid,
  output logic             o_err
);

  // One counter serves the rx data bytes, the read timeout and the tx bytes;
  // those phases never overlap.
  localparam int CW = 4;

  state_t           state, state_n;
  logic             is_write;
  logic [7:0]       addr_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;

  logic             rx_fire, tx_fire, cnt_last, rd_expired;
  logic             rd_addr_ok, wr_addr_ok;
  logic [WIDTH-1:0] shift_in;

  assign rx_fire    = i_rx_valid & o_rx_ready;
  assign tx_fire    = o_tx_valid & i_tx_ready;
  assign cnt_last   = (cnt == CW'(NB - 1));
  assign rd_expired = (cnt == CW'(RD_TIMEOUT - 1));
  assign shift_in   = (shift << 8) | WIDTH'(i_rx_data);

  // Range checks use the full address byte, so e.g. 0x25 is out of a 32-entry
  // write range even though its low bits would alias to entry 5.
  assign rd_addr_ok = ({24'd0, i_rx_data} < 32'(DEPTH + DEPTH_RO));
  assign wr_addr_ok = ({24'd0, addr_q} < 32'(DEPTH));

  // Gated by reset_n so the port reads 0 while reset is held.
  assign o_rx_ready = reset_n &
                      ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA));

  always_comb begin
    state_n    = state;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_w_en     = 1'b0;
    o_r_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          if ((i_rx_data == OP_WRITE) || (i_rx_data == OP_READ)) state_n = ST_ADDR;
          else                                                  state_n = ST_TX_ERR;
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          if (is_write)        state_n = ST_DATA;
          else if (rd_addr_ok) state_n = ST_RSTROBE;
          else                 state_n = ST_TX_ERR;
        end
      end
      ST_DATA: begin
        if (rx_fire && cnt_last) state_n = wr_addr_ok ? ST_WSTROBE : ST_TX_ERR;
      end
      ST_WSTROBE: begin
        o_w_en  = 1'b1;
        state_n = ST_TX_ACK;
      end
      ST_RSTROBE: begin
        o_r_en  = 1'b1;
        state_n = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (i_r_valid)       state_n = ST_TX_DATA;
        else if (rd_expired) state_n = ST_TX_ERR;
      end
      ST_TX_DATA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shift[WIDTH-1 -: 8];
        if (tx_fire && cnt_last) state_n = ST_IDLE;
      end
      ST_TX_ACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = RSP_ACK;
        if (tx_fire) state_n = ST_IDLE;
      end
      ST_TX_ERR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = RSP_ERR;
        if (tx_fire) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      addr_q    <= 8'h00;
      cnt       <= '0;
      shift     <= '0;
      o_w_addr  <= '0;
      o_w_value <= '0;
      o_r_addr  <= '0;
      o_err     <= 1'b0;
    end else begin
      state <= state_n;
      o_err <= (state_n == ST_TX_ERR) && (state != ST_TX_ERR);
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            is_write <= (i_rx_data == OP_WRITE);
            cnt      <= '0;
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            addr_q <= i_rx_data;
            cnt    <= '0;
            if (!is_write && rd_addr_ok) o_r_addr <= RAW'(i_rx_data);
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            shift <= shift_in;
            cnt   <= cnt + 1'b1;
            // Write port registers only change on a write that will strobe,
            // so they hold the last real write across other commands.
            if (cnt_last && wr_addr_ok) begin
              o_w_addr  <= AW'(addr_q);
              o_w_value <= shift_in;
            end
          end
        end
        ST_RSTROBE: cnt <= '0;
        ST_RWAIT: begin
          if (i_r_valid) begin
            shift <= i_r_value;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TX_DATA: begin
          if (tx_fire) begin
            shift <= shift << 8;
            cnt   <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// tb/tb_reg_cmd_decoder.sv - self-checking bench for reg_cmd_decoder

module tb_reg_cmd_decoder;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int DEPTH_RO = 32;
  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int RAW = $clog2(DEPTH + DEPTH_RO);
  localparam int NREG = DEPTH + DEPTH_RO;
  localparam int TMO = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       i_rx_data = 8'h00;
  logic             i_rx_valid = 1'b0;
  logic             o_rx_ready;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             i_tx_ready = 1'b0;
  logic             o_w_en;
  logic [AW-1:0]    o_w_addr;
  logic [WIDTH-1:0] o_w_value;
  logic             o_r_en;
  logic [RAW-1:0]   o_r_addr;
  logic [WIDTH-1:0] i_r_value = '0;
  logic             i_r_valid = 1'b0;
  logic             o_err;

  reg_cmd_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_RO(DEPTH_RO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_w_en(o_w_en), .o_w_addr(o_w_addr), .o_w_value(o_w_value),
    .o_r_en(o_r_en), .o_r_addr(o_r_addr), .i_r_value(i_r_value), .i_r_valid(i_r_valid),
    .o_err(o_err)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register block contents (written by the DUT) and the reference model.
  logic [WIDTH-1:0] rb_mem [0:NREG-1];
  logic [WIDTH-1:0] exp_mem[0:NREG-1];
  int rb_lat = 1;

  // Event monitor, sampled mid-cycle.
  int cyc = 0;
  int w_cnt = 0, r_cnt = 0, e_cnt = 0;
  int rx_cyc = 0, w_cyc = 0, r_cyc = 0, e_cyc = 0;
  logic [AW-1:0]    last_w_addr = '0;
  logic [WIDTH-1:0] last_w_value = '0;
  logic [RAW-1:0]   last_r_addr = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset_n) begin
      if (i_rx_valid && o_rx_ready) rx_cyc = cyc;
      if (o_w_en) begin
        w_cnt++; w_cyc = cyc;
        last_w_addr = o_w_addr; last_w_value = o_w_value;
        rb_mem[o_w_addr] = o_w_value;
      end
      if (o_r_en) begin r_cnt++; r_cyc = cyc; last_r_addr = o_r_addr; end
      if (o_err) begin e_cnt++; e_cyc = cyc; end
    end
  end

  // Register block read side: answers rb_lat cycles after o_r_en (0 = never).
  initial begin
    int cd;
    logic [RAW-1:0] ra;
    cd = 0; ra = '0;
    forever begin
      @(posedge clk); #1;
      i_r_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin i_r_valid = 1'b1; i_r_value = rb_mem[ra]; end
      end
      if (reset_n && o_r_en && rb_lat > 0) begin cd = rb_lat; ra = o_r_addr; end
    end
  end

  logic [7:0] cmd_q[$];
  logic [7:0] exp_q[$];

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int budget;
    if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    i_rx_valid = 1'b1; i_rx_data = b;
    budget = 0;
    @(negedge clk);
    while (!o_rx_ready && budget < 50) begin @(negedge clk); budget++; end
    if (budget >= 50) chk("rx_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input bit rnd);
    int got, budget, last_x;
    bit stall;
    logic [7:0] prev;
    got = 0; budget = 0; last_x = 0; stall = 1'b0; prev = 8'h00;
    while (got < exp_q.size() && budget < 200) begin
      i_tx_ready = (hold > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      i_rx_valid = 1'b1; i_rx_data = 8'h57;   // must not be consumed
      @(negedge clk);
      if (o_tx_valid) begin
        chk("rx_ready_during_tx", 64'(o_rx_ready), 64'(0));
        if (stall) chk("tx_data_stable", 64'(o_tx_data), 64'(prev));
        if (hold > 0) hold--;
      end
      stall = o_tx_valid && !i_tx_ready;
      prev = o_tx_data;
      if (o_tx_valid && i_tx_ready) begin
        chk("tx_byte", 64'(o_tx_data), 64'(exp_q[got]));
        if (!rnd && got > 0) chk("tx_back_to_back", 64'(cyc - last_x), 64'(1));
        last_x = cyc;
        got++;
      end
      @(posedge clk); #1;
      budget++;
    end
    i_rx_valid = 1'b0; i_tx_ready = 1'b0;
    if (got < exp_q.size()) chk("tx_response_timeout", 64'(got), 64'(exp_q.size()));
  endtask

  task automatic run_cmd(input int exp_w, input int exp_r, input int exp_e,
                         input int hold, input bit rnd);
    int w0, r0, e0;
    w0 = w_cnt; r0 = r_cnt; e0 = e_cnt;
    foreach (cmd_q[i]) send_byte(cmd_q[i], rnd);
    collect(hold, rnd);
    @(negedge clk);
    chk("tx_idle_after_rsp", 64'(o_tx_valid), 64'(0));
    chk("rx_ready_after_rsp", 64'(o_rx_ready), 64'(1));
    @(posedge clk); #1;
    chk("w_en_pulses", 64'(w_cnt - w0), 64'(exp_w));
    chk("r_en_pulses", 64'(r_cnt - r0), 64'(exp_r));
    chk("err_pulses", 64'(e_cnt - e0), 64'(exp_e));
  endtask

  task automatic push_word(input logic [WIDTH-1:0] v, input bit to_cmd);
    for (int i = NB - 1; i >= 0; i--) begin
      if (to_cmd) cmd_q.push_back(v[i*8 +: 8]);
      else        exp_q.push_back(v[i*8 +: 8]);
    end
  endtask

  task automatic run_write(input logic [7:0] addr, input logic [WIDTH-1:0] v,
                           input int hold, input bit rnd);
    bit ok;
    ok = (int'(addr) < DEPTH);
    cmd_q = {8'h57, addr};
    push_word(v, 1'b1);
    exp_q.delete();
    if (ok) begin exp_q.push_back(8'h4B); exp_mem[int'(addr)] = v; end
    else    exp_q.push_back(8'h3F);
    run_cmd(ok ? 1 : 0, 0, ok ? 0 : 1, hold, rnd);
    if (ok) begin
      chk("w_addr", 64'(last_w_addr), 64'(addr));
      chk("w_value", 64'(last_w_value), 64'(v));
      chk("w_en_timing", 64'(w_cyc - rx_cyc), 64'(1));
    end else begin
      chk("werr_timing", 64'(e_cyc - rx_cyc), 64'(1));
    end
  endtask

  task automatic run_read(input logic [7:0] addr, input int lat,
                          input int hold, input bit rnd);
    bit ok, answered;
    ok = (int'(addr) < NREG);
    answered = (lat >= 1 && lat <= TMO);
    rb_lat = lat;
    cmd_q = {8'h52, addr};
    exp_q.delete();
    if (ok && answered) push_word(exp_mem[int'(addr)], 1'b0);
    else exp_q.push_back(8'h3F);
    run_cmd(0, ok ? 1 : 0, (ok && answered) ? 0 : 1, hold, rnd);
    if (ok) begin
      chk("r_addr", 64'(last_r_addr), 64'(addr));
      chk("r_en_timing", 64'(r_cyc - rx_cyc), 64'(1));
      if (!answered) chk("timeout_timing", 64'(e_cyc - r_cyc), 64'(1 + TMO));
    end
    rb_lat = 1;
  endtask

  task automatic run_bad(input logic [7:0] op, input bit rnd);
    cmd_q = {op};
    exp_q = {8'h3F};
    run_cmd(0, 0, 1, 0, rnd);
    chk("op_err_timing", 64'(e_cyc - rx_cyc), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_ready"}, 64'(o_rx_ready), 64'(0));
    chk({tag, "_tx_valid"}, 64'(o_tx_valid), 64'(0));
    chk({tag, "_tx_data"}, 64'(o_tx_data), 64'(0));
    chk({tag, "_w_en"}, 64'(o_w_en), 64'(0));
    chk({tag, "_w_addr"}, 64'(o_w_addr), 64'(0));
    chk({tag, "_w_value"}, 64'(o_w_value), 64'(0));
    chk({tag, "_r_en"}, 64'(o_r_en), 64'(0));
    chk({tag, "_r_addr"}, 64'(o_r_addr), 64'(0));
    chk({tag, "_err"}, 64'(o_err), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, op;
    for (int i = 0; i < NREG; i++) begin
      logic [WIDTH-1:0] v;
      v = WIDTH'($urandom);
      rb_mem[i] = v; exp_mem[i] = v;
    end
    rb_mem[37] = 16'hBEEF; exp_mem[37] = 16'hBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_reset", 64'(o_rx_ready), 64'(1));
    @(posedge clk); #1;

    run_write(8'h05, 16'h1234, 0, 1'b0);
    run_read(8'h05, 1, 0, 1'b0);
    run_read(8'h25, 1, 0, 1'b0);
    run_bad(8'h41, 1'b0);
    run_write(8'h20, 16'h0001, 0, 1'b0);
    run_read(8'h40, 1, 0, 1'b0);
    run_read(8'h3F, 1, 0, 1'b0);
    run_read(8'h05, 1, 10, 1'b0);
    run_read(8'h05, 0, 0, 1'b0);
    run_read(8'h05, TMO, 0, 1'b0);
    run_read(8'h05, TMO + 1, 0, 1'b0);
    run_write(8'h1F, 16'hA5C3, 0, 1'b0);
    run_read(8'h1F, 2, 0, 1'b0);

    send_byte(8'h57, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_cmd_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rerelease", 64'(o_rx_ready), 64'(1));
    @(posedge clk); #1;
    run_write(8'h06, 16'hABCD, 0, 1'b0);
    run_read(8'h06, 1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: run_write(8'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom), $urandom_range(0, 3), 1'b1);
        1: run_write(8'($urandom_range(DEPTH, 255)), WIDTH'($urandom), 0, 1'b1);
        2: run_read(8'($urandom_range(0, NREG - 1)), $urandom_range(1, TMO), $urandom_range(0, 3), 1'b1);
        3: run_read(8'($urandom_range(NREG, 255)), 1, 0, 1'b1);
        4: begin
          op = 8'($urandom);
          if (op == 8'h57 || op == 8'h52) op = 8'h00;
          run_bad(op, 1'b1);
        end
        default: begin
          a = 8'($urandom_range(0, NREG - 1));
          run_read(a, ($urandom_range(0, 1) == 0) ? 0 : TMO + 1, 0, 1'b1);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
